// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I load/store at a time, validates it, and
// sequences a single access to the DataMemory port before returning a response.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR   = 3'd1;
    localparam logic [2:0] RD   = 3'd2;
    localparam logic [2:0] CAP  = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    logic [2:0]  state;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic [2:0]  size;
    logic [32:0] end_addr;
    logic        bad_funct3;
    logic        misaligned;
    logic        req_fault;
    logic        active;

    // Access size from funct3[1:0]; the 11 encoding is rejected by bad_funct3.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        end_addr   = {1'b0, req_addr} + {30'b0, size};
        bad_funct3 = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                            : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_fault  = bad_funct3 || misaligned || (end_addr > 33'(MEM_BYTES));
    end

    // Store vs load is carried by the WR/RD state choice rather than a latched we bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_funct3 <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_funct3 <= req_funct3;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        fault_q    <= req_fault;
                        rdata_q    <= '0;
                        if (req_fault)   state <= RESP;
                        else if (req_we) state <= WR;
                        else             state <= RD;
                    end
                end
                WR:  state <= RESP;
                RD:  state <= CAP;
                CAP: begin
                    rdata_q <= mem_rdata;
                    state   <= RESP;
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign active     = (state == WR) || (state == RD) || (state == CAP);
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
    assign mem_read   = (state == RD) || (state == CAP);
    assign mem_write  = (state == WR);
    assign mem_funct3 = active ? lat_funct3 : '0;
    assign mem_addr   = active ? lat_addr   : '0;
    assign mem_wdata  = active ? lat_wdata  : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data memory, transaction-level reference
// model checked every cycle, and directed vectors with literal expectations.
module tb_load_store_unit;

    localparam int unsigned MB = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.MEM_BYTES(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // DataMemory stand-in: synchronous write, combinational extended read.
    logic [7:0]  env_mem [MB];
    logic [9:0]  ea;
    logic [31:0] ew;

    initial for (int i = 0; i < int'(MB); i++) env_mem[i] = 8'h00;

    always @(posedge clk) begin
        if (mem_write) begin
            env_mem[mem_addr[9:0]] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00) env_mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                env_mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
                env_mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        ea = mem_addr[9:0];
        ew = {env_mem[ea + 10'd3], env_mem[ea + 10'd2], env_mem[ea + 10'd1], env_mem[ea]};
        mem_rdata = '0;
        if (mem_read) begin
            case (mem_funct3)
                3'b000:  mem_rdata = {{24{ew[7]}}, ew[7:0]};
                3'b001:  mem_rdata = {{16{ew[15]}}, ew[15:0]};
                3'b100:  mem_rdata = {24'b0, ew[7:0]};
                3'b101:  mem_rdata = {16'b0, ew[15:0]};
                default: mem_rdata = ew;
            endcase
        end
    end

    // Reference model: one outstanding transaction, k = cycles since acceptance.
    logic [7:0]  ref_mem [MB];
    bit          m_busy = 1'b0;
    int          m_k, m_lat, m_sz;
    bit          m_we, m_fault;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wdata, m_rdata, m_w;
    bit          x_rd, x_wr, x_act;

    initial for (int i = 0; i < int'(MB); i++) ref_mem[i] = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_k >= m_lat - 1 && resp_ready) m_busy = 1'b0;
            else m_k++;
        end else if (req_valid) begin
            m_busy  = 1'b1;
            m_k     = 0;
            m_we    = req_we;
            m_f3    = req_funct3;
            m_addr  = req_addr;
            m_wdata = req_wdata;
            m_sz    = (m_f3[1:0] == 2'b00) ? 1 : (m_f3[1:0] == 2'b01) ? 2 : 4;
            if (m_we) m_fault = !(m_f3 == 3'd0 || m_f3 == 3'd1 || m_f3 == 3'd2);
            else      m_fault = (m_f3 == 3'd3 || m_f3 == 3'd6 || m_f3 == 3'd7);
            if (m_sz == 2 && (m_addr % 2) != 0) m_fault = 1'b1;
            if (m_sz == 4 && (m_addr % 4) != 0) m_fault = 1'b1;
            if (longint'(m_addr) + longint'(m_sz) > longint'(MB)) m_fault = 1'b1;
            m_lat   = m_fault ? 1 : (m_we ? 2 : 3);
            m_rdata = '0;
            if (!m_fault && m_we)
                for (int i = 0; i < m_sz; i++) ref_mem[m_addr + i] = m_wdata[8*i +: 8];
            if (!m_fault && !m_we) begin
                m_w = '0;
                for (int i = 0; i < m_sz; i++) m_w = m_w | (32'(ref_mem[m_addr + i]) << (8 * i));
                if (m_f3 == 3'd0 && m_w[7])  m_w = m_w | 32'hFFFF_FF00;
                if (m_f3 == 3'd1 && m_w[15]) m_w = m_w | 32'hFFFF_0000;
                m_rdata = m_w;
            end
        end
        #1;
        if (rst) begin
            chk1("rst_resp_valid", resp_valid, 1'b0);
            chk1("rst_resp_fault", resp_fault, 1'b0);
            chk32("rst_resp_rdata", resp_rdata, 32'h0);
            chk1("rst_mem_read", mem_read, 1'b0);
            chk1("rst_mem_write", mem_write, 1'b0);
            chk32("rst_mem_funct3", {29'b0, mem_funct3}, 32'h0);
            chk32("rst_mem_addr", mem_addr, 32'h0);
            chk32("rst_mem_wdata", mem_wdata, 32'h0);
        end else if (!m_busy) begin
            chk1("idle_req_ready", req_ready, 1'b1);
            chk1("idle_resp_valid", resp_valid, 1'b0);
            chk1("idle_mem_read", mem_read, 1'b0);
            chk1("idle_mem_write", mem_write, 1'b0);
            chk32("idle_mem_addr", mem_addr, 32'h0);
        end else begin
            x_rd  = !m_fault && !m_we && m_k <= 1;
            x_wr  = !m_fault && m_we && m_k == 0;
            x_act = x_rd || x_wr;
            chk1("busy_req_ready", req_ready, 1'b0);
            chk1("resp_valid", resp_valid, m_k >= m_lat - 1);
            chk1("mem_read", mem_read, x_rd);
            chk1("mem_write", mem_write, x_wr);
            chk32("mem_addr", mem_addr, x_act ? m_addr : 32'h0);
            chk32("mem_funct3", {29'b0, mem_funct3}, x_act ? {29'b0, m_f3} : 32'h0);
            chk32("mem_wdata", mem_wdata, x_act ? m_wdata : 32'h0);
            if (m_k >= m_lat - 1) begin
                chk32("resp_rdata", resp_rdata, m_rdata);
                chk1("resp_fault", resp_fault, m_fault);
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk1("lit_accept_timeout", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic x_fault, input logic [31:0] x_rdata,
                       input int x_lat);
        int lat;
        issue(we, f3, a, wd);
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk32("lit_latency", 32'(lat), 32'(x_lat));
        chk1("lit_fault", resp_fault, x_fault);
        chk32("lit_rdata", resp_rdata, x_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk1("lit_req_ready_after_reset", req_ready, 1'b1);

        txn(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 2);
        txn(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF, 3);
        txn(1'b1, 3'b000, 32'h1, 32'h0000_00AA, 1'b0, 32'h0, 2);
        txn(1'b0, 3'b000, 32'h1, 32'h0, 1'b0, 32'hFFFF_FFAA, 3);
        txn(1'b0, 3'b100, 32'h1, 32'h0, 1'b0, 32'h0000_00AA, 3);
        txn(1'b1, 3'b001, 32'h3, 32'h0000_1234, 1'b1, 32'h0, 1);
        txn(1'b0, 3'b010, 32'h2, 32'h0, 1'b1, 32'h0, 1);
        txn(1'b0, 3'b010, 32'h3FC, 32'h0, 1'b0, 32'h0, 3);
        txn(1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h0, 1);
        txn(1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0, 1);
        txn(1'b1, 3'b001, 32'h2, 32'hFFFF_8001, 1'b0, 32'h0, 2);
        txn(1'b0, 3'b001, 32'h2, 32'h0, 1'b0, 32'hFFFF_8001, 3);
        txn(1'b0, 3'b101, 32'h2, 32'h0, 1'b0, 32'h0000_8001, 3);
        txn(1'b1, 3'b100, 32'h8, 32'h0, 1'b1, 32'h0, 1);
        txn(1'b0, 3'b000, 32'h3FF, 32'h0, 1'b0, 32'h0, 3);

        // Back-pressure: response held while a new request waits.
        @(negedge clk);
        resp_ready = 1'b0;
        txn(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h8001_AAEF, 3);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h4;
        req_wdata  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("lit_hold_req_ready", req_ready, 1'b0);
            chk1("lit_hold_resp_valid", resp_valid, 1'b1);
            chk32("lit_hold_rdata", resp_rdata, 32'h8001_AAEF);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk1("lit_release_idle", req_ready, 1'b1);
        chk1("lit_release_resp_valid", resp_valid, 1'b0);
        @(negedge clk);
        chk1("lit_next_accepted", req_ready, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("lit_next_resp_valid", resp_valid, 1'b1);
        chk32("lit_next_rdata", resp_rdata, 32'h0);

        // Reset during CAP abandons the load.
        issue(1'b0, 3'b010, 32'h4, 32'h0);
        @(negedge clk);
        chk1("lit_cap_mem_read", mem_read, 1'b1);
        rst = 1'b1;
        #1;
        chk1("lit_rst_mem_read", mem_read, 1'b0);
        chk1("lit_rst_resp_valid", resp_valid, 1'b0);
        chk32("lit_rst_mem_addr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk1("lit_no_resp_after_rst", resp_valid, 1'b0);
        end
        txn(1'b1, 3'b010, 32'h4, 32'h1234_5678, 1'b0, 32'h0, 2);
        txn(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'h1234_5678, 3);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024: data memory size in bytes; any access reaching or exceeding it faults.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1  pipeline presents a memory operation.
REQ-005 SHALL have port req_ready  out  1  unit accepts an operation this cycle.
REQ-006 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  in  3  RV32I load/store funct3.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-010 SHALL have port resp_valid  out  1  response available.
REQ-011 SHALL have port resp_ready  in  1  pipeline consumes response.
REQ-012 SHALL have port resp_rdata  out  32  load result as returned by memory; 0 for stores and faults.
REQ-013 SHALL have port resp_fault  out  1  operation rejected, no memory access made.
REQ-014 SHALL have ports mem_read, mem_write (out 1 each), mem_funct3 (out 3), mem_addr (out 32), mem_wdata (out 32), mem_rdata (in 32), driving the DataMemory port of the same names.

Function
REQ-015 SHALL implement FSM states IDLE, WR, RD, CAP, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid & req_ready.
REQ-017 SHALL latch req_we, req_funct3, req_addr, req_wdata on acceptance; the request inputs are ignored in all other states.
REQ-018 SHALL flag a fault on acceptance for any of:
- load funct3 in {011, 110, 111};
- store funct3 not in {000, 001, 010};
- halfword with addr[0]=1;
- word with addr[1:0]!=00;
- addr + access size > MEM_BYTES.
REQ-019 SHALL transition on acceptance as follows: faulting request -> RESP; valid store -> WR; valid load -> RD.
REQ-020 SHALL, in WR, assert mem_write=1 for exactly one cycle with latched funct3/addr/wdata, then go to RESP.
REQ-021 SHALL, in RD, assert mem_read=1 and go to CAP.
REQ-022 SHALL, in CAP, keep mem_read=1 with addr and funct3 unchanged, register mem_rdata into resp_rdata at the closing edge, then go to RESP.
REQ-023 SHALL never assert mem_read and mem_write together, and SHALL keep both at 0 in IDLE and RESP.
REQ-024 SHALL drive mem_funct3, mem_addr and mem_wdata from the latched request in WR, RD and CAP, and to 0 elsewhere.
REQ-025 SHALL, in RESP, hold resp_valid=1 and keep resp_rdata and resp_fault stable until resp_ready=1, then return to IDLE on that edge.
REQ-026 SHALL NOT accept a new request in the RESP cycle in which resp_ready=1; the next acceptance is earliest one cycle later, in IDLE.
REQ-027 SHALL produce response latency from the acceptance edge of 1 cycle for faults, 2 cycles for stores and 3 cycles for loads, in each case to resp_valid first high.
REQ-028 SHALL perform no sign or zero extension itself; the memory performs it per funct3.
REQ-029 SHALL keep resp_fault=0 and resp_rdata=0 for successful stores.

Reset
REQ-030 SHALL, when rst is asserted, immediately and asynchronously force:
- state=IDLE;
- req_ready=1 (after release), resp_valid=0, resp_fault=0;
- resp_rdata=0;
- mem_read=0, mem_write=0, mem_funct3=0, mem_addr=0, mem_wdata=0.
REQ-031 SHALL, on reset asserted mid-operation (WR, RD, CAP, RESP), abandon the operation with no response; a store already committed at an earlier edge is not undone.

Verification
REQ-032 SHALL cover: SW 0xDEADBEEF @0x0 then LW @0x0 -> one mem_write pulse, resp_valid 2 cycles after acceptance; load resp_rdata=0xDEADBEEF at 3 cycles, resp_fault=0.
REQ-033 SHALL cover: SB 0xAA @0x1, then LB @0x1 and LBU @0x1 -> resp_rdata 0xFFFFFFAA and 0x000000AA respectively.
REQ-034 SHALL cover: SH @0x3 and LW @0x2 -> resp_fault=1 at 1 cycle latency, mem_read and mem_write never asserted, resp_rdata=0.
REQ-035 SHALL cover: LW @0x3FC -> success; LW @0x400 with MEM_BYTES=1024 -> fault; funct3=011 load -> fault.
REQ-036 SHALL cover: hold resp_ready=0 for 5 cycles with req_valid=1 -> resp_valid and data stable, req_ready=0; release -> IDLE, next request accepted one cycle later.
REQ-037 SHALL cover: assert rst during CAP of LW @0x4 -> mem_read drops in the same cycle, no resp_valid; next SW/LW @0x4 of 0x12345678 completes normally.
